spi_master_ctrl: RTL and testbench

//  SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives the serial link answered by
//  the system's SPI responder. Accepts one parallel word per valid/ready handshake and shifts it
//  out on MOSI while shifting in MISO. Returns the received word with a one-cycle valid pulse.

---
 rtl/spi_master_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first): one word per valid/ready handshake,
// full-duplex shift, received word returned with a single-cycle RX_VALID pulse.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  CS_N
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  // MSB goes straight to MOSI on accept, so only the remaining bits are kept
  logic [DATA_WIDTH-2:0]   tx_rest_q, tx_rest_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    miso_q;
  logic                    div_end;

  // State and datapath registers; RST also aborts any transfer in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_rest_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_rest_q  <= tx_rest_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      miso_q     <= MISO;
    end
  end

  assign div_end = (div_q == DIV_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_rest_d  = tx_rest_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    unique case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        cs_n_d     = 1'b1;
        sclk_d     = 1'b0;
        if (TX_VALID) begin
          state_d    = SETUP;
          tx_ready_d = 1'b0;
          cs_n_d     = 1'b0;
          mosi_d     = TX_DATA[DATA_WIDTH-1];
          tx_rest_d  = TX_DATA[DATA_WIDTH-2:0];
          rx_shift_d = '0;
          div_d      = '0;
          bit_d      = '0;
        end
      end

      SETUP: begin
        if (div_end) begin
          div_d      = '0;
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso_q};
          state_d    = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit unless the last one is already out
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
            if (bit_q != BIT_LAST) begin
              mosi_d    = tx_rest_q[DATA_WIDTH-2];
              tx_rest_d = tx_rest_q << 1;
            end
          end else if (bit_q == BIT_END) begin
            // Final low half-period has elapsed
            state_d    = DONE;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso_q};
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        tx_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TX_READY = tx_ready_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: scoreboard of expected words pushed on accept and
// popped on RX_VALID; second instance covers the 16-bit / CLK_DIV=2 configuration.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;

  logic [15:0] tx_data16 = 16'h0000;
  logic        tx_valid16 = 1'b0;
  logic        tx_ready16;
  logic [15:0] rx_data16;
  logic        rx_valid16;
  logic        sclk16;
  logic        mosi16;
  logic        cs_n16;

  // 0: loopback, 1: tied high, 2: responder model
  logic [1:0]  miso_mode = 2'd0;
  logic [7:0]  resp_word = 8'h3C;
  logic [7:0]  resp_sh = 8'h00;
  logic        resp_prev_cs = 1'b1;
  logic        resp_prev_sclk = 1'b0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  exp_rx_q[$];
  logic [7:0]  exp_tx_q[$];
  int          acc_q[$];

  logic        chk_accept = 1'b0;
  logic        chk_ready = 1'b0;
  logic        chk_rst = 1'b0;
  logic        in_xfer = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        mosi_one = 1'b0;
  logic [7:0]  mosi_cap = 8'h00;
  logic [7:0]  acc_msb_word = 8'h00;
  int          rises = 0;
  int          cs_high_cnt = 0;
  int          last_rx_cyc = -1000;
  logic        hold_mode = 1'b0;
  int          hold_start_cyc = 0;

  spi_master_ctrl u_dut (
    .CLK      (clk),
    .RST      (rst),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .SCLK     (sclk),
    .MOSI     (mosi),
    .MISO     (miso),
    .CS_N     (cs_n)
  );

  spi_master_ctrl #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut16 (
    .CLK      (clk),
    .RST      (rst),
    .TX_DATA  (tx_data16),
    .TX_VALID (tx_valid16),
    .TX_READY (tx_ready16),
    .RX_DATA  (rx_data16),
    .RX_VALID (rx_valid16),
    .SCLK     (sclk16),
    .MOSI     (mosi16),
    .MISO     (mosi16),
    .CS_N     (cs_n16)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign miso = (miso_mode == 2'd0) ? mosi :
                (miso_mode == 2'd1) ? 1'b1 : resp_sh[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Responder model: loads its word when selected, shifts on each SCLK fall
  always @(negedge clk) begin
    if (resp_prev_cs && !cs_n) resp_sh = resp_word;
    else if (resp_prev_sclk && !sclk && !cs_n) resp_sh = resp_sh << 1;
    resp_prev_cs   = cs_n;
    resp_prev_sclk = sclk;
  end

  // Monitor / scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (chk_rst) begin
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      chk_rst = 1'b0;
    end
    if (chk_ready) begin
      check("tx_ready_after_rx", 32'(tx_ready), 32'd1);
      check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
      chk_ready = 1'b0;
    end
    if (chk_accept) begin
      check("cs_n_low_after_accept", 32'(cs_n), 32'd0);
      check("tx_ready_low_busy", 32'(tx_ready), 32'd0);
      check("mosi_msb_setup", 32'(mosi), 32'(acc_msb_word[7]));
      chk_accept = 1'b0;
      in_xfer    = 1'b1;
      rises      = 0;
      mosi_cap   = 8'h00;
      mosi_one   = 1'b0;
    end
    if (in_xfer && sclk && !prev_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (in_xfer && !cs_n && mosi) mosi_one = 1'b1;
    if (rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) begin
        check("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e_rx, e_tx;
        int         a;
        e_rx = exp_rx_q.pop_front();
        e_tx = exp_tx_q.pop_front();
        a    = acc_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e_rx));
        check("mosi_bits", 32'(mosi_cap), 32'(e_tx));
        check("sclk_rises", 32'(rises), 32'd8);
        check("rx_latency", 32'(cyc - a + 1), 32'd69);
        if (e_tx == 8'h00) check("mosi_quiet", 32'(mosi_one), 32'd0);
      end
      in_xfer     = 1'b0;
      last_rx_cyc = cyc;
      chk_ready   = 1'b1;
    end
    if (cs_n) cs_high_cnt++;
    else cs_high_cnt = 0;
    if (rst) begin
      exp_rx_q.delete();
      exp_tx_q.delete();
      acc_q.delete();
      in_xfer    = 1'b0;
      chk_accept = 1'b0;
      chk_ready  = 1'b0;
      chk_rst    = 1'b1;
    end else if (tx_valid && tx_ready === 1'b1) begin
      case (miso_mode)
        2'd0:    exp_rx_q.push_back(tx_data);
        2'd1:    exp_rx_q.push_back(8'hFF);
        default: exp_rx_q.push_back(resp_word);
      endcase
      exp_tx_q.push_back(tx_data);
      acc_q.push_back(cyc + 1);
      acc_msb_word = tx_data;
      chk_accept   = 1'b1;
      if (hold_mode && last_rx_cyc > hold_start_cyc) begin
        check("accept_after_rx", 32'(cyc + 1 - last_rx_cyc), 32'd2);
        check("cs_gap_min", 32'(cs_high_cnt >= 1), 32'd1);
      end
    end
    prev_sclk = sclk;
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("ready_timeout", 32'd0, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("rx_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, got, prev, acc16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset16_tx_ready", 32'(tx_ready16), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Loopback, then MISO tied high with zero data, then responder model
    miso_mode = 2'd0; send(8'hA5); wait_done();
    miso_mode = 2'd1; send(8'h00); wait_done();
    miso_mode = 2'd2; resp_word = 8'h3C; send(8'h96); wait_done();
    resp_word = 8'hC1; send(8'h0F); wait_done();
    miso_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom));
      wait_done();
    end

    // Abort at the 4th SCLK rise
    send(8'h5A);
    n = 0; got = 0; prev = 0;
    while (got < 4 && n < 400) begin
      @(posedge clk); #1;
      if (sclk && prev == 0) got++;
      prev = int'(sclk);
      n++;
    end
    if (n >= 400) check("rise_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    send(8'h81); wait_done();

    // TX_VALID held high with data changing every cycle
    hold_start_cyc = cyc;
    hold_mode      = 1'b1;
    tx_valid       = 1'b1;
    tx_data        = 8'hC6;
    n = 0; got = 0;
    while (got < 2 && n < 400) begin
      @(posedge clk); #1;
      if (rx_valid) got++;
      tx_data = 8'($urandom);
      n++;
    end
    tx_valid = 1'b0;
    if (n >= 400) check("hold_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    hold_mode = 1'b0;

    // 16-bit instance, CLK_DIV=2, loopback
    tx_data16  = 16'hBEEF;
    tx_valid16 = 1'b1;
    @(posedge clk); #1;
    tx_valid16 = 1'b0;
    acc16 = cyc;
    tx_data16 = 16'h1234;
    n = 0;
    while (rx_valid16 !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("rx16_timeout", 32'd0, 32'd1);
    check("rx16_data", 32'(rx_data16), 32'h0000BEEF);
    check("rx16_latency", 32'(cyc - acc16 + 1), 32'd67);
    @(posedge clk); #1;
    check("rx16_pulse", 32'(rx_valid16), 32'd0);
    check("rx16_ready", 32'(tx_ready16), 32'd1);
    check("rx16_hold", 32'(rx_data16), 32'h0000BEEF);
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
